// File: rtl/fsm_sequence_sender_if.sv
// -----------------------------------------------------------------------------
// fsm_sequence_sender_if
//   Frame request and character stream of the hex-sequence sender.
//   Ports (signal bundle):
//     start       host -> sender  frame request
//     data_in     host -> sender  word to send, 4*NUM_DIGITS bits
//     char_ready  sink -> sender  downstream accepts the current character
//     ascii_char  sender -> sink  current character
//     char_valid  sender -> sink  ascii_char valid
//     busy        sender -> host  frame in progress
//     done        sender -> host  one-cycle pulse after the closing 0x0A
//   master: the sender itself; slave: the host/sink side driving it.
// -----------------------------------------------------------------------------
interface fsm_sequence_sender_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    start;
    logic [4*NUM_DIGITS-1:0] data_in;
    logic                    char_ready;
    logic [7:0]              ascii_char;
    logic                    char_valid;
    logic                    busy;
    logic                    done;

    modport master (
        input  start, data_in, char_ready,
        output ascii_char, char_valid, busy, done
    );

    modport slave (
        output start, data_in, char_ready,
        input  ascii_char, char_valid, busy, done
    );
endinterface

// File: rtl/fsm_sequence_sender.sv
// -----------------------------------------------------------------------------
// fsm_sequence_sender
//   Emits one framed ASCII hex word per accepted start: 0x0A, NUM_DIGITS hex
//   digits (most significant nibble first), 0x0A. Each character is placed on
//   ascii_char GAP_CYCLES clocks before char_valid rises and is held until the
//   sink takes it (char_valid & char_ready at a rising edge).
//   Ports:
//     clk  system clock, rising edge
//     rst  synchronous reset, active low
//     bus  fsm_sequence_sender_if.master (start/data_in/char_ready in,
//          ascii_char/char_valid/busy/done out)
// -----------------------------------------------------------------------------
module fsm_sequence_sender #(
    parameter int NUM_DIGITS = 8,
    parameter int GAP_CYCLES = 2,
    parameter int UPPERCASE  = 1
) (
    input logic                   clk,
    input logic                   rst,
    fsm_sequence_sender_if.master bus
);
    localparam int DATA_W = 4 * NUM_DIGITS;
    localparam int IDX_W  = $clog2(NUM_DIGITS + 2);
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam logic [7:0]       LF         = 8'h0A;
    localparam logic [7:0]       ALPHA_BASE = (UPPERCASE != 0) ? 8'h41 : 8'h61;

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        SEND
    } state_t;

    state_t              state_q,  state_d;
    logic [DATA_W-1:0]   data_q,   data_d;
    logic [IDX_W-1:0]    idx_q,    idx_d;
    logic [GAP_W-1:0]    gap_q,    gap_d;
    logic [7:0]          char_q,   char_d;
    logic                valid_q,  valid_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return ALPHA_BASE + {4'h0, n} - 8'd10;
    endfunction

    // Index 0 and LAST_IDX are the framing line feeds; index i in between
    // carries nibble NUM_DIGITS-i, so the most significant digit goes first.
    function automatic logic [7:0] char_at(input logic [IDX_W-1:0]  idx,
                                           input logic [DATA_W-1:0] data);
        logic [DATA_W-1:0] shifted;
        if (idx == '0 || idx == LAST_IDX) return LF;
        shifted = data >> (4 * (NUM_DIGITS - int'(idx)));
        return nibble_to_ascii(shifted[3:0]);
    endfunction

    // State and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational process.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            char_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-register values.
    always_comb begin
        logic [IDX_W-1:0] idx_inc;
        // NOTE: every target gets a default (hold, or 0 for the done pulse)
        // before the case, so no path leaves a value unassigned and no latch
        // is inferred.
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        char_d  = char_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        idx_inc = idx_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    data_d = bus.data_in;
                    idx_d  = '0;
                    char_d = LF;
                    busy_d = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        gap_d   = GAP_LOAD;
                        state_d = GAP;
                    end else begin
                        valid_d = 1'b1;
                        state_d = SEND;
                    end
                end
            end

            // The gap counter is loaded with GAP_CYCLES-1 in the same edge that
            // loads ascii_char, so valid rises exactly GAP_CYCLES edges later.
            GAP: begin
                if (gap_q == '0) begin
                    valid_d = 1'b1;
                    state_d = SEND;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end

            SEND: begin
                if (bus.char_ready) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d  = idx_inc;
                        char_d = char_at(idx_inc, data_q);
                        if (GAP_CYCLES > 0) begin
                            valid_d = 1'b0;
                            gap_d   = GAP_LOAD;
                            state_d = GAP;
                        end
                    end else begin
                        // Closing line feed taken: ascii_char keeps 0x0A.
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Outputs come straight from registers.
    always_comb begin
        bus.ascii_char = char_q;
        bus.char_valid = valid_q;
        bus.busy       = busy_q;
        bus.done       = done_q;
    end
endmodule

// File: tb/tb_fsm_sequence_sender.sv
// -----------------------------------------------------------------------------
// tb_fsm_sequence_sender
//   Directed bench for fsm_sequence_sender. Expected characters are pushed to a
//   scoreboard queue when a frame is requested and popped on each transfer.
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fsm_sequence_sender;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fsm_sequence_sender_if #(.NUM_DIGITS(8)) bus ();
    fsm_sequence_sender_if #(.NUM_DIGITS(2)) bus6 ();

    fsm_sequence_sender #(
        .NUM_DIGITS(8),
        .GAP_CYCLES(2),
        .UPPERCASE (1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    fsm_sequence_sender #(
        .NUM_DIGITS(2),
        .GAP_CYCLES(0),
        .UPPERCASE (0)
    ) dut6 (
        .clk(clk),
        .rst(rst),
        .bus(bus6)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    bit         done_seen = 1'b0;
    bit         prev_valid = 1'b0;
    int         low_cnt = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n, input bit upper);
        string digits;
        digits = upper ? "0123456789ABCDEF" : "0123456789abcdef";
        return digits[n];
    endfunction

    task automatic push_frame(input logic [31:0] d);
        exp_q.push_back(8'h0A);
        for (int k = 7; k >= 0; k--) exp_q.push_back(hex_char(d[4*k +: 4], 1'b1));
        exp_q.push_back(8'h0A);
    endtask

    // One clock of the main DUT: score the transfer about to happen at the
    // rising edge, then sample the settled outputs at the next falling edge.
    task automatic clock();
        if (rst === 1'b1 && bus.char_valid === 1'b1 && bus.char_ready === 1'b1) begin
            if (exp_q.size() == 0) check("extra_char", exp_q.size(), 1);
            else                   check("char", bus.ascii_char, exp_q.pop_front());
        end
        @(negedge clk);
        if (bus.done === 1'b1) done_seen = 1'b1;
        if (bus.busy !== 1'b1) low_cnt = 0;
        if (bus.busy === 1'b1 && bus.char_valid === 1'b0) begin
            low_cnt++;
            if (exp_q.size() > 0) check("setup_char", bus.ascii_char, exp_q[0]);
        end
        if (bus.char_valid === 1'b1 && !prev_valid) begin
            check("setup_len", low_cnt, 2);
            low_cnt = 0;
        end
        prev_valid = (bus.char_valid === 1'b1);
    endtask

    // Runs one frame whose start is already applied. Optionally stalls the sink
    // on 0x34, pulses start mid-frame, and chains a new start on the done cycle.
    task automatic run_frame(input string tag, input int exp_len, input bit stall,
                             input bit mid_start, input bit chain, input logic [31:0] chain_data);
        int cyc;
        bit stalled;
        cyc       = 0;
        stalled   = 1'b0;
        done_seen = 1'b0;
        clock();
        bus.start = 1'b0;
        while (!done_seen && cyc < 200) begin
            if (mid_start && cyc == 10) begin
                check({tag, "_busy_mid"}, bus.busy, 1'b1);
                bus.start   = 1'b1;
                bus.data_in = 32'hFFFF_FFFF;
            end else if (mid_start) begin
                bus.start = 1'b0;
            end
            if (stall && !stalled && bus.char_valid === 1'b1 && bus.ascii_char === 8'h34) begin
                stalled        = 1'b1;
                bus.char_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    clock();
                    cyc++;
                    check({tag, "_stall_valid"}, bus.char_valid, 1'b1);
                    check({tag, "_stall_char"}, bus.ascii_char, 8'h34);
                end
                bus.char_ready = 1'b1;
            end
            clock();
            cyc++;
        end
        check({tag, "_done_time"}, cyc, exp_len);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        if (stall) check({tag, "_stall_hit"}, stalled, 1'b1);
        if (chain) begin
            push_frame(chain_data);
            bus.start   = 1'b1;
            bus.data_in = chain_data;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         guard;
        bit         found;
        logic [7:0] q6[$];
        int         valid_run;
        int         done_cyc;

        rst            = 1'b0;
        bus.start      = 1'b1;
        bus.data_in    = 32'h2B46_00AF;
        bus.char_ready = 1'b1;
        bus6.start     = 1'b1;
        bus6.data_in   = 8'hAF;
        bus6.char_ready = 1'b1;
        @(negedge clk);

        // 1: reset dominates a held start
        for (int r = 0; r < 3; r++) clock();
        check("rst_char",  bus.ascii_char, 8'h00);
        check("rst_valid", bus.char_valid, 1'b0);
        check("rst_busy",  bus.busy,       1'b0);
        check("rst_done",  bus.done,       1'b0);
        check("rst6_valid", bus6.char_valid, 1'b0);
        bus.start  = 1'b0;
        bus6.start = 1'b0;
        rst        = 1'b1;
        clock();
        check("idle_busy", bus.busy, 1'b0);

        // 2: plain frame
        push_frame(32'h2B46_00AF);
        bus.start   = 1'b1;
        bus.data_in = 32'h2B46_00AF;
        run_frame("t2", 30, 1'b0, 1'b0, 1'b0, 32'h0);
        clock();
        check("t2_done_pulse", bus.done, 1'b0);

        // 3: sink stalls while 0x34 is offered
        push_frame(32'h2B46_00AF);
        bus.start = 1'b1;
        run_frame("t3", 35, 1'b1, 1'b0, 1'b0, 32'h0);
        clock();

        // 4: mid-frame start ignored, start on done cycle accepted
        push_frame(32'h2B46_00AF);
        bus.start   = 1'b1;
        bus.data_in = 32'h2B46_00AF;
        run_frame("t4a", 30, 1'b0, 1'b1, 1'b1, 32'h0000_0001);
        run_frame("t4b", 30, 1'b0, 1'b0, 1'b0, 32'h0);
        clock();

        // 5: reset while the 4th character is on the line
        push_frame(32'h2B46_00AF);
        bus.start   = 1'b1;
        bus.data_in = 32'h2B46_00AF;
        done_seen   = 1'b0;
        clock();
        bus.start = 1'b0;
        found = 1'b0;
        guard = 0;
        while (!found && guard < 40) begin
            if (bus.ascii_char === 8'h34) found = 1'b1;
            else begin
                clock();
                guard++;
            end
        end
        check("t5_reach_4th", found, 1'b1);
        rst = 1'b0;
        clock();
        rst = 1'b1;
        check("t5_char",  bus.ascii_char, 8'h00);
        check("t5_valid", bus.char_valid, 1'b0);
        check("t5_busy",  bus.busy,       1'b0);
        exp_q.delete();
        for (int w = 0; w < 40; w++) clock();
        check("t5_no_done", done_seen, 1'b0);
        push_frame(32'h1234_5678);
        bus.start   = 1'b1;
        bus.data_in = 32'h1234_5678;
        run_frame("t5", 30, 1'b0, 1'b0, 1'b0, 32'h0);
        clock();

        // 6: two digits, no gap, lowercase
        q6.push_back(8'h0A);
        q6.push_back(hex_char(4'hA, 1'b0));
        q6.push_back(hex_char(4'hF, 1'b0));
        q6.push_back(8'h0A);
        bus6.start   = 1'b1;
        bus6.data_in = 8'hAF;
        @(negedge clk);
        bus6.start = 1'b0;
        valid_run  = 0;
        done_cyc   = -1;
        for (int c = 0; c < 10 && done_cyc < 0; c++) begin
            if (bus6.done === 1'b1) done_cyc = c;
            if (bus6.char_valid === 1'b1) begin
                valid_run++;
                if (q6.size() == 0) check("t6_extra_char", q6.size(), 1);
                else                check("t6_char", bus6.ascii_char, q6.pop_front());
            end
            if (done_cyc < 0) @(negedge clk);
        end
        check("t6_valid_run", valid_run, 4);
        check("t6_done_time", done_cyc, 4);
        check("t6_queue_empty", q6.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
